// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM loader.
//   state_t : loader FSM state encoding
//   STATE_W : width of the state encoding
package rom_loader_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/rom_loader_csum.sv
// Running additive checksum over acknowledged write data. Wraps modulo
// 2^DATA_WIDTH.
// Ports:
//   clk, rst : clock, async active-high reset
//   clr      : clear the sum (takes priority over en)
//   en       : add data into the sum this cycle
//   data     : word to accumulate
//   sum      : current checksum
module rom_loader_csum #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] sum
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum + data;
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Boot-time copy engine: reads ROM words 0..LENGTH-1 through a registered
// synchronous ROM and writes each to DST_BASE+index over a req/ack port.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | rom_cs high, rom_addr = index
//   LATCH | ROM data valid, captured into wr_data, wr_addr computed
//   WRITE | wr_req high, waiting for wr_ack
//   DONE  | one-cycle done pulse
//
// Ports:
//   clk, rst           : clock, async active-high reset
//   start              : begin a copy (ignored unless IDLE)
//   busy, done         : copy in progress / completion pulse
//   rom_cs, rom_addr   : ROM read port
//   rom_data           : registered ROM output
//   wr_req, wr_addr,
//   wr_data, wr_ack    : destination write handshake
//   checksum           : sum of written words
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int ROM_AW     = 16,
   parameter int DST_AW     = 16,
   parameter int DATA_WIDTH = 8,
   parameter int LENGTH     = 1024,
   parameter int DST_BASE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  rom_cs,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  wr_req,
   output logic [DST_AW-1:0]     wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ack,
   output logic [DATA_WIDTH-1:0] checksum
);

   // One extra index bit so LENGTH = 2^ROM_AW still has a representable last index.
   localparam int                IDX_W    = ROM_AW + 1;
   localparam bit                EMPTY    = (LENGTH == 0);
   localparam logic [IDX_W-1:0]  LAST_IDX = EMPTY ? '0 : IDX_W'(LENGTH - 1);
   localparam logic [DST_AW-1:0] BASE     = DST_AW'(DST_BASE);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             start_acc;
   logic             wr_fire;
   logic             last_word;

   assign start_acc = (state == IDLE) && start;
   assign wr_fire   = (state == WRITE) && wr_ack;
   assign last_word = (idx == LAST_IDX);
   assign rom_addr  = idx[ROM_AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      rom_cs    = 1'b0;
      wr_req    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = EMPTY ? DONE : FETCH;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            rom_cs    = 1'b1;
            state_nxt = LATCH;
         end
         LATCH: begin
            busy      = 1'b1;
            state_nxt = WRITE;
         end
         WRITE: begin
            busy   = 1'b1;
            wr_req = 1'b1;
            if (wr_ack) begin
               state_nxt = last_word ? DONE : FETCH;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         if (start_acc) begin
            idx <= '0;
         end else if (wr_fire && !last_word) begin
            idx <= idx + 1'b1;
         end
         // Address and data are only loaded here, so they hold through WRITE stalls.
         if (state == LATCH) begin
            wr_data <= rom_data;
            wr_addr <= BASE + DST_AW'(idx);
         end
      end
   end

`ifdef ROM_LOADER_CHECKSUM_EN
   rom_loader_csum #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_csum (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_acc),
      .en   (wr_fire),
      .data (wr_data),
      .sum  (checksum)
   );
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: nominal copy, ack stalls, LENGTH=0,
// ignored start/ack, mid-copy reset and destination address wrap.
module tb_rom_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] rom_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

`ifdef ROM_LOADER_CHECKSUM_EN
   localparam logic [7:0] EXP_CSUM = 8'hAA;
`else
   localparam logic [7:0] EXP_CSUM = 8'h00;
`endif

   // Instance A: LENGTH=4, DST_BASE=0x100
   logic        start_a = 1'b0, ack_a = 1'b0;
   logic        busy_a, done_a, rom_cs_a, wr_req_a;
   logic [15:0] rom_addr_a, wr_addr_a;
   logic [7:0]  rom_data_a = '0, wr_data_a, csum_a;

   rom_loader #(.ROM_AW(16), .DST_AW(16), .DATA_WIDTH(8), .LENGTH(4), .DST_BASE(16'h100)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .rom_cs(rom_cs_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
      .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ack(ack_a),
      .checksum(csum_a));

   // Instance B: LENGTH=0
   logic        start_b = 1'b0;
   logic        busy_b, done_b, rom_cs_b, wr_req_b;
   logic [15:0] rom_addr_b, wr_addr_b;
   logic [7:0]  rom_data_b = '0, wr_data_b, csum_b;

   rom_loader #(.ROM_AW(16), .DST_AW(16), .DATA_WIDTH(8), .LENGTH(0), .DST_BASE(0)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .rom_cs(rom_cs_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
      .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ack(1'b1),
      .checksum(csum_b));

   // Instance C: DST_AW=8, DST_BASE=0xFE, LENGTH=4
   logic        start_c = 1'b0;
   logic        busy_c, done_c, rom_cs_c, wr_req_c;
   logic [15:0] rom_addr_c;
   logic [7:0]  wr_addr_c;
   logic [7:0]  rom_data_c = '0, wr_data_c, csum_c;

   rom_loader #(.ROM_AW(16), .DST_AW(8), .DATA_WIDTH(8), .LENGTH(4), .DST_BASE(8'hFE)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
      .rom_cs(rom_cs_c), .rom_addr(rom_addr_c), .rom_data(rom_data_c),
      .wr_req(wr_req_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_ack(1'b1),
      .checksum(csum_c));

   // Synchronous ROM models: data valid the cycle after rom_cs.
   always @(posedge clk) begin
      if (rom_cs_a) rom_data_a <= rom_mem[rom_addr_a[1:0]];
      if (rom_cs_b) rom_data_b <= rom_mem[rom_addr_b[1:0]];
      if (rom_cs_c) rom_data_c <= rom_mem[rom_addr_c[1:0]];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Ack driver for A. 0: tied high, 1: random 0-5 stalls,
   // 2: ack when requested plus spurious acks, 3: ack except at 0x102.
   int ack_mode = 0;
   int stall    = 2;
   always @(negedge clk) begin
      case (ack_mode)
         0: ack_a = 1'b1;
         1: begin
            if (wr_req_a) begin
               if (stall > 0) begin
                  ack_a = 1'b0;
                  stall--;
               end else begin
                  ack_a = 1'b1;
                  stall = int'($urandom_range(0, 5));
               end
            end else begin
               ack_a = 1'b0;
            end
         end
         2: ack_a = wr_req_a ? 1'b1 : 1'(($urandom_range(0, 1)));
         default: ack_a = wr_req_a && (wr_addr_a != 16'h102);
      endcase
   end

   // Monitors: write log, rom_cs count, hold-stability violations.
   logic [15:0] log_addr [$];
   logic [7:0]  log_data [$];
   logic [7:0]  log_addr_c [$];
   int          cs_cnt = 0, viol = 0, cs_b_cnt = 0, wrq_b_cnt = 0;
   bit          pend = 0;
   logic [15:0] p_addr = '0;
   logic [7:0]  p_data = '0;

   always @(posedge clk) begin
      if (wr_req_a && pend && (wr_addr_a != p_addr || wr_data_a != p_data)) viol++;
      pend   = wr_req_a && !ack_a;
      p_addr = wr_addr_a;
      p_data = wr_data_a;
      if (wr_req_a && ack_a) begin
         log_addr.push_back(wr_addr_a);
         log_data.push_back(wr_data_a);
      end
      if (rom_cs_a) cs_cnt++;
      if (rom_cs_b) cs_b_cnt++;
      if (wr_req_b) wrq_b_cnt++;
      if (wr_req_c) log_addr_c.push_back(wr_addr_c);
   end

   task automatic clear_logs();
      log_addr.delete();
      log_data.delete();
      cs_cnt = 0;
      viol   = 0;
   endtask

   // Pulses start_a and counts cycles until done; cycle 1 is the one right
   // after the start edge, so N zero-wait words give 3N+1.
   task automatic run_a(input bit repulse, output int cycles);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      check("busy_after_start", 32'(busy_a), 32'd1);
      cycles = 1;
      while (!done_a && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         start_a = repulse && (cycles == 4 || cycles == 7 || cycles == 10);
      end
      start_a = 1'b0;
      check("busy_in_done_cycle", 32'(busy_a), 32'd0);
   endtask

   task automatic check_log_a(input string tag);
      check({tag, "_wr_count"}, 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < log_addr.size()) begin
            check({tag, "_wr_addr"}, 32'(log_addr[i]), 32'h100 + 32'(i));
            check({tag, "_wr_data"}, 32'(log_data[i]), 32'(rom_mem[i]));
         end
      end
   endtask

   int  cyc;
   bit  found;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {28'd0, busy_a, done_a, rom_cs_a, wr_req_a}, 32'd0);
      check("rst_rom_addr", 32'(rom_addr_a), 32'd0);
      check("rst_wr_addr", 32'(wr_addr_a), 32'd0);
      check("rst_wr_data", 32'(wr_data_a), 32'd0);
      check("rst_csum", 32'(csum_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Nominal copy, zero-wait ack
      ack_mode = 0;
      clear_logs();
      run_a(1'b0, cyc);
      check("nominal_cycles", 32'(cyc), 32'd13);
      check_log_a("nominal");
      check("nominal_cs_pulses", 32'(cs_cnt), 32'd4);
      check("nominal_csum", 32'(csum_a), 32'(EXP_CSUM));
      repeat (3) @(posedge clk);
      #1;
      check("csum_held", 32'(csum_a), 32'(EXP_CSUM));

      // Random ack stalls
      ack_mode = 1;
      clear_logs();
      run_a(1'b0, cyc);
      check("stall_finished", 32'(cyc < 200), 32'd1);
      check_log_a("stall");
      check("stall_cs_pulses", 32'(cs_cnt), 32'd4);
      check("stall_hold_viol", 32'(viol), 32'd0);
      check("stall_csum", 32'(csum_a), 32'(EXP_CSUM));
      repeat (2) @(posedge clk);

      // Start re-pulsed while busy, spurious acks while wr_req=0
      ack_mode = 2;
      clear_logs();
      run_a(1'b1, cyc);
      check("repulse_cycles", 32'(cyc), 32'd13);
      check_log_a("repulse");
      check("repulse_cs_pulses", 32'(cs_cnt), 32'd4);
      repeat (4) @(posedge clk);
      #1;
      check("repulse_no_restart", 32'(busy_a), 32'd0);

      // Reset while the third word's write is pending
      ack_mode = 3;
      clear_logs();
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      found = 0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (wr_req_a && wr_addr_a == 16'h102) found = 1;
      end
      check("rst_reached_word2", 32'(found), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("abort_ctrl", {28'd0, busy_a, done_a, rom_cs_a, wr_req_a}, 32'd0);
      check("abort_rom_addr", 32'(rom_addr_a), 32'd0);
      check("abort_wr_addr", 32'(wr_addr_a), 32'd0);
      check("abort_wr_data", 32'(wr_data_a), 32'd0);
      check("abort_csum", 32'(csum_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ack_mode = 0;
      repeat (2) @(posedge clk);
      clear_logs();
      run_a(1'b0, cyc);
      check("restart_cycles", 32'(cyc), 32'd13);
      check_log_a("restart");
      check("restart_csum", 32'(csum_a), 32'(EXP_CSUM));

      // LENGTH=0
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      check("len0_done", 32'(done_b), 32'd1);
      check("len0_busy", 32'(busy_b), 32'd0);
      @(posedge clk);
      #1;
      check("len0_done_pulse", 32'(done_b), 32'd0);
      check("len0_no_cs", 32'(cs_b_cnt), 32'd0);
      check("len0_no_wr", 32'(wrq_b_cnt), 32'd0);

      // Destination wrap with DST_AW=8
      log_addr_c.delete();
      @(negedge clk);
      start_c = 1'b1;
      @(posedge clk);
      #1;
      start_c = 1'b0;
      cyc = 1;
      while (!done_c && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("wrap_cycles", 32'(cyc), 32'd13);
      check("wrap_count", 32'(log_addr_c.size()), 32'd4);
      if (log_addr_c.size() == 4) begin
         check("wrap_addr0", 32'(log_addr_c[0]), 32'hFE);
         check("wrap_addr1", 32'(log_addr_c[1]), 32'hFF);
         check("wrap_addr2", 32'(log_addr_c[2]), 32'h00);
         check("wrap_addr3", 32'(log_addr_c[3]), 32'h01);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time copy engine that sits directly downstream of the synchronous ROM.
- On a start pulse it walks ROM addresses 0..LENGTH-1, drives chip-select and address into the ROM, and captures each registered data word.
- Each word goes to a destination RAM/bus port through a req/ack write handshake.
- Used to shadow the boot ROM into main memory before the CPU is released from reset.

Parameters:
- ROM_AW, 16: ROM address width; matches the ROM's ADDR_WIDTH.
- DST_AW, 16: destination address width.
- DATA_WIDTH, 8: word width; matches the ROM's DATA_WIDTH.
- LENGTH, 1024: number of words copied; legal range 0..2^ROM_AW.
- DST_BASE, 0: destination address of word 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word's write is acknowledged.
- rom_cs  out  1  ROM chip-select.
- rom_addr  out  ROM_AW  ROM address.
- rom_data  in  DATA_WIDTH  ROM data_out; registered; valid the cycle after rom_cs=1.
- wr_req  out  1  destination write request.
- wr_addr  out  DST_AW  destination address.
- wr_data  out  DATA_WIDTH  destination data.
- wr_ack  in  1  destination accepts the write on a clk edge where wr_req=1 and wr_ack=1.
- checksum  out  DATA_WIDTH  running additive checksum (see Optional Feature).

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rom_cs, wr_req = 0; rom_addr, wr_addr, wr_data, checksum, index counter = 0.
- IDLE:
  - start=1 and LENGTH>0 -> FETCH, index=0, busy=1.
  - start=1 and LENGTH=0 -> DONE; no ROM or write activity.
- FETCH (1 cycle): rom_cs=1, rom_addr=index -> LATCH.
- LATCH (1 cycle): rom_cs=0; rom_data now valid; register it into wr_data. Set wr_addr = (DST_BASE + index) mod 2^DST_AW -> WRITE.
- WRITE: wr_req=1; wr_addr and wr_data are held stable until acknowledged.
  - On wr_ack=1: deassert wr_req next cycle.
  - If index = LENGTH-1 -> DONE; else index+1 and -> FETCH.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Throughput: 3 cycles per word minimum (ack in first WRITE cycle). Start-to-done for N words with zero-wait ack = 3N+1 cycles after the start edge.
- start while busy: ignored; no restart, no queueing.
- wr_ack while wr_req=0: ignored.
- rom_cs is never high outside FETCH, so ROM data_out holds its last value between fetches.
- Destination address wrap: modulo 2^DST_AW, no error flag.
- Index counter is ROM_AW+1 bits wide so LENGTH=2^ROM_AW terminates correctly.
- rst mid-copy: immediate abort to the reset values; a subsequent start restarts from word 0.

Optional Feature:
- Macro ROM_LOADER_CHECKSUM_EN.
- When defined:
  - checksum clears on an accepted start.
  - On each acknowledged write, checksum <= checksum + wr_data (mod 2^DATA_WIDTH).
  - checksum is stable and valid from the done cycle until the next start.
- When undefined: checksum is tied to 0 and no adder logic is built.

Decomposition:
- Package rom_loader_pkg: state enum (IDLE, FETCH, LATCH, WRITE, DONE) and a localparam for the state width.
- Parameters stay module-level.
- One natural sub-module: rom_loader_csum, the checksum accumulator with clr/en/data inputs, instantiated only under ROM_LOADER_CHECKSUM_EN.

Test Plan:
- LENGTH=4, ROM={11,22,33,44}, DST_BASE=0x100, wr_ack tied 1:
  - writes (0x100,11),(0x101,22),(0x102,33),(0x103,44);
  - done exactly 13 cycles after the start edge;
  - checksum=0xAA when ROM_LOADER_CHECKSUM_EN is defined.
- Random wr_ack stalls of 0-5 cycles: wr_addr and wr_data stay stable while wr_req=1; exactly one write per word; rom_cs pulses exactly 4 times.
- LENGTH=0: done pulses the cycle after start; rom_cs and wr_req never assert.
- start re-pulsed during a copy, plus wr_ack pulses while wr_req=0: sequence unchanged, no extra writes.
- rst asserted while wr_req=1 on word 2: all outputs 0 asynchronously. A following start copies from word 0 again.
- DST_AW=8, DST_BASE=0xFE, LENGTH=4: wr_addr sequence 0xFE, 0xFF, 0x00, 0x01.
